// File: rtl/booth4_mul_ext_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
//   flush     : synchronous kill of any pending or in-flight operation
//   in_valid  : op/rs1/rs2 are valid        in_ready  : unit can accept
//   op        : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1, rs2  : multiplicand, multiplier (N bits)
//   out_valid : result is valid             out_ready : consumer takes result
//   result    : selected half of the product
//   busy      : unit is calculating or holding a result
// master = issuing side (execute stage), slave = multiplier.
interface booth4_mul_ext_if #(
  parameter int unsigned N = 32
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         busy;

  modport master (
    output flush, in_valid, op, rs1, rs2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, rs1, rs2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/booth4_mul_ext.sv
// Sequential radix-4 Booth multiplier covering all four RV32M multiply ops.
// Operands are extended to N+2 bits (sign or zero per op) so the full signed
// and unsigned ranges are legal; N/2+1 Booth steps run one per cycle.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : booth4_mul_ext_if slave (handshakes, operands, result, flush, busy)
module booth4_mul_ext #(
  parameter int unsigned N = 32
) (
  input logic             clk,
  input logic             rst,
  booth4_mul_ext_if.slave bus
);

  localparam int unsigned CW = $clog2(N/2+2);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [N+1:0]   m_q, m_d;
  logic [N+3:0]   acc_q, acc_d;
  logic [N+2:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   result_q, result_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic           rs1_signed, rs2_signed;
  logic [N+1:0]   rs1_ext, rs2_ext;
  logic [N+3:0]   m_wide, pp, acc_sum, acc_nxt;
  logic [N+2:0]   q_nxt;
  logic [2*N-1:0] prod_lo;

  always_comb begin
    // rs1 is unsigned only for MULHU; rs2 is signed only for MUL and MULH.
    rs1_signed = (bus.op != 2'b11);
    rs2_signed = (bus.op[1] == 1'b0);
    rs1_ext    = {{2{rs1_signed & bus.rs1[N-1]}}, bus.rs1};
    rs2_ext    = {{2{rs2_signed & bus.rs2[N-1]}}, bus.rs2};

    // Booth recoding of the current triplet into {0, +-M, +-2M}.
    m_wide = {{2{m_q[N+1]}}, m_q};
    case (q_q[2:0])
      3'b001, 3'b010: pp = m_wide;
      3'b011:         pp = m_wide << 1;
      3'b100:         pp = -(m_wide << 1);
      3'b101, 3'b110: pp = -m_wide;
      default:        pp = '0;
    endcase

    acc_sum = acc_q + pp;
    // Arithmetic shift of the {acc, Q} pair right by two.
    acc_nxt = {{2{acc_sum[N+3]}}, acc_sum[N+3:2]};
    q_nxt   = {acc_sum[1:0], q_q[N+2:2]};
    // Low 2N bits of {acc, Q[N+2:1]}; valid once the last step has run.
    prod_lo = {acc_nxt[N-3:0], q_nxt[N+2:1]};

    state_d     = state_q;
    m_d         = m_q;
    acc_d       = acc_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          m_d        = rs1_ext;
          acc_d      = '0;
          q_d        = {rs2_ext, 1'b0};
          cnt_d      = CW'(N/2+1);
          op_d       = bus.op;
          state_d    = StCalc;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StCalc: begin
        acc_d = acc_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          result_d    = (op_q == 2'b00) ? prod_lo[N-1:0] : prod_lo[2*N-1:N];
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase

    // Flush overrides both an accept in IDLE and a handoff in DONE.
    if (bus.flush) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      m_q         <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_booth4_mul_ext.sv
module tb_booth4_mul_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  booth4_mul_ext_if #(.N(8)) bus ();

  booth4_mul_ext #(.N(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation; returns at the negedge following the accept edge.
  task automatic start(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.rs1      = a;
    bus.rs2      = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom());
    bus.rs1      = 8'($urandom());
    bus.rs2      = 8'($urandom());
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
    int lat;
    start(o, a, b);
    wait_done(lat);
    if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
    else check({tag, "_timeout"}, bus.out_valid, 1'b1);
    check(tag, bus.result, exp);
    take();
  endtask

  function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] a,
                                       input logic [7:0] b);
    logic signed [15:0] pa, pb, p;
    pa = (o != 2'b11)    ? {{8{a[7]}}, a} : {8'h00, a};
    pb = (o[1] == 1'b0)  ? {{8{b[7]}}, b} : {8'h00, b};
    p  = pa * pb;
    return (o == 2'b00) ? p[7:0] : p[15:8];
  endfunction

  initial begin
    int lat;
    bit ov_seen;
    logic [7:0] vals [12];
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h55, 8'h7F,
             8'h80, 8'h81, 8'hAA, 8'hFD, 8'hFE, 8'hFF};

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.rs1       = 8'h00;
    bus.rs2       = 8'h00;
    bus.out_ready = 1'b0;

    #2 rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_result", bus.result, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Most-negative operands, extreme unsigned, mixed signedness.
    run("mul_80_80",    2'b00, 8'h80, 8'h80, 8'h00, 5);
    run("mulh_80_80",   2'b01, 8'h80, 8'h80, 8'h40, 5);
    run("mulhu_ff_ff",  2'b11, 8'hFF, 8'hFF, 8'hFE, 5);
    run("mul_ff_ff",    2'b00, 8'hFF, 8'hFF, 8'h01, 5);
    run("mulhsu_ff_ff", 2'b10, 8'hFF, 8'hFF, 8'hFF, 5);
    run("mulh_ff_ff",   2'b01, 8'hFF, 8'hFF, 8'h00, 5);

    // Output stall: 7 x -3 = -21 held for 10 cycles.
    start(2'b00, 8'h07, 8'hFD);
    check("stall_busy", bus.busy, 1'b1);
    check("stall_in_ready_calc", bus.in_ready, 1'b0);
    wait_done(lat);
    check("stall_lat", lat, 5);
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_result", bus.result, 8'hEB);
      check("stall_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_in_ready", bus.in_ready, 1'b1);
    check("release_out_valid", bus.out_valid, 1'b0);
    check("release_busy", bus.busy, 1'b0);

    // Flush sampled at edge E0+2.
    start(2'b01, 8'h12, 8'h34);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("flush_in_ready_e4", bus.in_ready, 1'b1);
    ov_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) ov_seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_out_valid", ov_seen, 1'b0);

    // Flush beats in_valid in IDLE.
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.rs1      = 8'h02;
    bus.rs2      = 8'h03;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle_busy", bus.busy, 1'b0);
    check("flush_idle_in_ready", bus.in_ready, 1'b1);

    // Flush beats out_ready in DONE; the next op still completes normally.
    start(2'b00, 8'h03, 8'h03);
    wait_done(lat);
    check("flushdone_result", bus.result, 8'h09);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("flushdone_out_valid", bus.out_valid, 1'b0);
    check("flushdone_in_ready", bus.in_ready, 1'b1);

    // Asynchronous reset in the middle of CALC.
    start(2'b00, 8'h21, 8'h43);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1'b1);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_result", bus.result, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    run("after_rst_5x5", 2'b00, 8'h05, 8'h05, 8'h19, 5);

    // Corner-value sweep against a behavioural product.
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < 12; j++) begin
          start(2'(o), vals[i], vals[j]);
          wait_done(lat);
          check($sformatf("sweep_op%0d_%02h_%02h", o, vals[i], vals[j]),
                bus.result, model(2'(o), vals[i], vals[j]));
          take();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
